regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (We/Rw/din) between two write-back producers: ALU (SRC_ALU) and load unit (SRC_MEM).
- Arbitrates round-robin with a valid/ready handshake and drives the register file from a registered output stage.
- Keeps a 32-entry pending-write scoreboard so decode can stall on read-after-write (RAW) hazards for the Ra/Rb read ports.
- Sits between execute/memory write-back and the register bank.

Parameters:
- BITS, 64, data width of din; matches the register bank.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- alu_valid  in  1  ALU write-back request.
- alu_ready  out  1  ALU request granted this cycle.
- alu_rd  in  5  ALU destination register.
- alu_data  in  BITS  ALU result.
- mem_valid  in  1  load write-back request.
- mem_ready  out  1  load request granted this cycle.
- mem_rd  in  5  load destination register.
- mem_data  in  BITS  load data.
- rf_we  out  1  to register bank We.
- rf_rw  out  5  to register bank Rw.
- rf_din  out  BITS  to register bank din.
- reserve_valid  in  1  decode issues an instruction writing reserve_rd.
- reserve_rd  in  5  destination being reserved.
- chk_ra  in  5  decode source A index.
- chk_rb  in  5  decode source B index.
- busy_a  out  1  scoreboard bit for chk_ra.
- busy_b  out  1  scoreboard bit for chk_rb.
- flush  in  1  pipeline flush.
- err_waw  out  1  sticky: reserve issued to an already-busy register.

Behaviour:
- Reset (rst_n=0, async):
  - rf_we=0, rf_rw=0, rf_din=0.
  - All busy bits 0; rr_ptr=SRC_ALU; err_waw=0.
  - alu_ready=mem_ready=0 while in reset.
- Arbitration (combinational ready):
  - Only one valid: grant it; rr_ptr <= the other source.
  - Both valid: grant the source rr_ptr points to; rr_ptr <= the other source.
  - Neither valid: no grant; rr_ptr holds.
  - A transfer is valid&&ready. The non-granted requester must hold valid, rd and data stable.
- Latency: a grant in cycle N gives rf_we=1, rf_rw=rd, rf_din=data throughout cycle N+1. The bank writes at the edge ending N+1.
  - Back-to-back grants sustain one write per cycle.
  - With no grant, rf_we=0 next cycle; rf_rw and rf_din hold their last values.
- x0 writes: a request with rd=0 is accepted (ready=1), but next cycle rf_we=0 and the scoreboard is untouched.
- Scoreboard:
  - Set: reserve_valid && reserve_rd!=0 sets busy[reserve_rd] at the clock edge.
  - Clear: rf_we=1 clears busy[rf_rw] at the edge ending that cycle.
  - Set and clear on the same index in the same cycle: set wins.
  - busy[0] is constant 0.
  - busy_a=busy[chk_ra] and busy_b=busy[chk_rb] read combinationally from current state; there is no forwarding of a same-cycle write.
- WAW: reserve_valid with busy[reserve_rd]=1 (rd!=0) sets err_waw. It stays set until reset; the busy bit stays 1.
- Flush (synchronous):
  - alu_ready=mem_ready=0 during flush.
  - All busy bits clear at the edge.
  - A write already in the output stage (rf_we=1 during flush) still completes.
  - reserve_valid during flush is ignored.
  - rr_ptr and err_waw are unaffected.
- Reset mid-operation: a pending output-stage write is dropped; rf_we goes 0 immediately.

Decomposition:
- Package regfile_pkg:
  - REG_ADDR_W=5, NUM_REGS=32.
  - Enum wb_src_t {SRC_ALU=0, SRC_MEM=1}.
  - Struct wb_req_t {valid, rd[4:0], data[BITS-1:0]}, parameterised via BITS in the user module.
- One sub-module: wb_rr_arbiter, a 2-way round-robin with rr_ptr state, outputs grant vector and selected source. Datapath mux, output stage and scoreboard remain in the top.

Test Plan:
- ALU only: alu_valid, rd=5, data=0xA5 in cycle 0 -> alu_ready=1 in cycle 0; rf_we=1, rf_rw=5, rf_din=0xA5 in cycle 1; then rf_we=0.
- Contention: both valid for 4 cycles, ALU rd=1/data=0x11, MEM rd=2/data=0x22 -> grants ALU, MEM, ALU, MEM; rf_rw sequence 1,2,1,2 one cycle later; each waiting requester holds.
- Scoreboard: reserve rd=7 in cycle 0 -> busy_a=1 with chk_ra=7 from cycle 1. MEM write rd=7 granted in cycle 3 -> rf_we in cycle 4, busy_a=0 from cycle 5. Reserve rd=7 and clear rd=7 in the same cycle -> busy stays 1.
- x0 and WAW: ALU rd=0 granted -> rf_we stays 0, busy unchanged. Reserve rd=9 twice without write-back -> err_waw=1 and sticky.
- Flush: busy bits 3 and 4 set, output stage holding a write to 3, flush=1 -> write to 3 still asserted, both ready=0, all busy=0 next cycle.
- Async reset: deassert rst_n mid-cycle while rf_we=1 -> rf_we=0 immediately without a clock edge; after release, rr_ptr=ALU and a simultaneous request grants ALU first.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file write-back path.
// Pure declarations; no logic, no latency, no flow control.
package regfile_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } wb_src_t;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin arbiter: combinational grant, rr_ptr advances past the winner.
// Zero-cycle grant; en=0 withholds all grants and freezes rr_ptr.
module wb_rr_arbiter
   import regfile_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] grant,
   output wb_src_t    sel
);

   wb_src_t rr_ptr;
   wb_src_t rr_ptr_nxt;

   always_comb begin
      grant      = 2'b00;
      sel        = rr_ptr;
      rr_ptr_nxt = rr_ptr;
      if (en && (req != 2'b00)) begin
         if (req == 2'b11) begin
            sel = rr_ptr;
         end else if (req[0]) begin
            sel = SRC_ALU;
         end else begin
            sel = SRC_MEM;
         end
         grant      = (sel == SRC_ALU) ? 2'b01 : 2'b10;
         rr_ptr_nxt = (sel == SRC_ALU) ? SRC_MEM : SRC_ALU;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= SRC_ALU;
      end else begin
         rr_ptr <= rr_ptr_nxt;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and load write-back, with a RAW scoreboard.
// Grant in cycle N drives rf_we/rf_rw/rf_din in N+1; loser holds request, ready low in reset/flush.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int BITS = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  alu_valid,
   output logic                  alu_ready,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [BITS-1:0]       alu_data,
   input  logic                  mem_valid,
   output logic                  mem_ready,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic [BITS-1:0]       mem_data,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_rw,
   output logic [BITS-1:0]       rf_din,
   input  logic                  reserve_valid,
   input  logic [REG_ADDR_W-1:0] reserve_rd,
   input  logic [REG_ADDR_W-1:0] chk_ra,
   input  logic [REG_ADDR_W-1:0] chk_rb,
   output logic                  busy_a,
   output logic                  busy_b,
   input  logic                  flush,
   output logic                  err_waw
);

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic [BITS-1:0]       data;
   } wb_req_t;

   wb_req_t       alu_req;
   wb_req_t       mem_req;
   wb_req_t       win_req;
   logic [1:0]    grant;
   wb_src_t       sel;
   logic          arb_en;
   logic          xfer;

   assign alu_req = '{valid: alu_valid, rd: alu_rd, data: alu_data};
   assign mem_req = '{valid: mem_valid, rd: mem_rd, data: mem_data};

   // Gating with rst_n keeps both readies low while reset is held.
   assign arb_en = rst_n & ~flush;

   wb_rr_arbiter u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (arb_en),
      .req   ({mem_valid, alu_valid}),
      .grant (grant),
      .sel   (sel)
   );

   assign alu_ready = grant[0];
   assign mem_ready = grant[1];
   assign win_req   = (sel == SRC_MEM) ? mem_req : alu_req;
   assign xfer      = (grant != 2'b00) && win_req.valid;

   // x0 requests are consumed but never reach the bank.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we  <= 1'b0;
         rf_rw  <= '0;
         rf_din <= '0;
      end else begin
         rf_we <= xfer && (win_req.rd != '0);
         if (xfer) begin
            rf_rw  <= win_req.rd;
            rf_din <= win_req.data;
         end
      end
   end

   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_nxt;
   logic                waw_hit;

   // Reservation is applied after the write-back clear so that set wins on a collision.
   always_comb begin
      busy_nxt = busy;
      waw_hit  = 1'b0;
      if (flush) begin
         busy_nxt = '0;
      end else begin
         if (rf_we) begin
            busy_nxt[rf_rw] = 1'b0;
         end
         if (reserve_valid && (reserve_rd != '0)) begin
            waw_hit              = busy[reserve_rd];
            busy_nxt[reserve_rd] = 1'b1;
         end
      end
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy    <= '0;
         err_waw <= 1'b0;
      end else begin
         busy    <= busy_nxt;
         err_waw <= err_waw | waw_hit;
      end
   end

   assign busy_a = busy[chk_ra];
   assign busy_b = busy[chk_rb];

endmodule
